transmitter: RTL and testbench

UART transmitter, 8N1, LSB first. It is the transmit-side counterpart of the existing `receiver` block. It accepts a byte over a valid/ready handshake, serialises it onto `tx` at the configured baud rate and signals completion. The default configuration is a 50 MHz system clock at 115200 baud: CLKS_PER_BIT = 434, about 8680 ns per bit. This matches the receiver's timing so the two can be looped back directly.

---
 rtl/transmitter.sv | 151 +++++++++++++++
 tb/tb_transmitter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/transmitter.sv
// rtl/transmitter.sv - UART 8N1 transmitter, LSB first; optional parity bit when PARITY_EN is defined
module transmitter #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter bit ODD_PARITY   = 1'b0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            sym_end;

`ifdef PARITY_EN
  logic            par_q, par_d;
`else
  logic            unused_odd_parity;
  assign unused_odd_parity = ODD_PARITY;
`endif

  // Last cycle of the current symbol; every symbol is CLKS_PER_BIT cycles.
  assign sym_end = (cnt_q == CNT_LAST);

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q != ST_IDLE);
  assign tx    = tx_q;
  assign done  = done_q;

  // State and datapath registers; tx is registered so it is glitch-free.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic; tx_d is the line level for the cycle after the edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = sym_end ? '0 : cnt_q + CNT_ONE;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
`ifdef PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        tx_d  = 1'b1;
        if (valid) begin
          shift_d = data_in;
`ifdef PARITY_EN
          par_d   = (^data_in) ^ ODD_PARITY;
`endif
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (sym_end) begin
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (sym_end) begin
          if (bit_q == 3'd7) begin
`ifdef PARITY_EN
            tx_d    = par_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end
`ifdef PARITY_EN
      ST_PARITY: begin
        if (sym_end) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (sym_end) begin
          tx_d    = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_transmitter.sv
// tb/tb_transmitter.sv - scoreboard bench for transmitter with a line-decoding receiver model
module tb_transmitter;

  localparam int N   = 12;
  localparam bit ODD = 1'b0;
`ifdef PARITY_EN
  localparam int SK  = 10;
`else
  localparam int SK  = 9;
`endif
  localparam int FRAME = (SK + 1) * N;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid = 1'b0;
  logic       ready, tx, busy, done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_done = 0;
  byte unsigned exp_q[$];

  bit         mon_active = 1'b0;
  bit         seen_start = 1'b0;
  int         mon_t = 0;
  int         start_cyc = 0;
  logic [7:0] mon_bits = 8'h00;
  logic       mon_par = 1'b0;

  transmitter #(
    .CLK_FREQ(50000000),
    .BAUD(115200),
    .CLKS_PER_BIT(N),
    .ODD_PARITY(ODD)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .data_in(data_in),
    .valid(valid),
    .ready(ready),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
  endtask

  // Receiver model: decode the line at mid-symbol and check done timing.
  always @(negedge clk) begin
    byte unsigned eb;
    int k;
    cyc++;
    if (!rstn) begin
      mon_active = 1'b0;
      seen_start = 1'b0;
    end else begin
      chk("ready_is_not_busy", ready, !busy);
      if (done) begin
        n_done++;
        if (seen_start) chk("frame_length", cyc - start_cyc, FRAME);
        else fail("done_without_frame");
        chk("ready_on_done", ready, 1);
        seen_start = 1'b0;
      end
      if (!mon_active) begin
        if (tx == 1'b0) begin
          mon_active = 1'b1;
          mon_t = 0;
          start_cyc = cyc;
          seen_start = 1'b1;
          mon_bits = 8'h00;
        end
      end else begin
        mon_t++;
        if (mon_t % N == N / 2) begin
          k = mon_t / N;
          if (k == 0) chk("start_bit", tx, 0);
          else if (k <= 8) mon_bits[k-1] = tx;
          else if (k < SK) mon_par = tx;
          else begin
            chk("stop_bit", tx, 1);
            if (exp_q.size() == 0) begin
              fail("unexpected_byte");
            end else begin
              eb = exp_q.pop_front();
              chk("rx_byte", mon_bits, eb);
`ifdef PARITY_EN
              chk("parity_bit", mon_par, (^eb) ^ ODD);
`endif
            end
            mon_active = 1'b0;
          end
        end
      end
    end
  end

  // Offer a byte at a negedge, wait for ready, return at the negedge after the accept edge.
  task automatic send(input byte unsigned b, input bit keep, output int waited);
    waited = 0;
    data_in = b;
    valid = 1'b1;
    while (!ready && waited < 2 * FRAME) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) begin
      fail("accept_timeout");
      valid = 1'b0;
    end else begin
      exp_q.push_back(b);
      @(negedge clk);
      chk("start_latency_tx", tx, 0);
      chk("busy_after_accept", busy, 1);
      if (!keep) valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (!done && g < 2 * FRAME) begin
      @(negedge clk);
      g++;
    end
    if (!done) fail("done_timeout");
    @(negedge clk);
  endtask

  initial begin
    int w;
    int d0;
    byte unsigned hello[13];
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
              8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};

    // Reset then idle
    repeat (5) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_ready", ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rstn = 1'b1;
    d0 = n_done;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
        chk("idle_lines", {tx, ready, busy, done}, 4'b1100);
    end
    chk("idle_no_done", n_done - d0, 0);

    // Single byte 'H'
    send(8'h48, 1'b0, w);
    wait_done();

    // Loopback message, valid held high
    d0 = n_done;
    for (int i = 0; i < 13; i++) begin
      send(hello[i], 1'b1, w);
      if (i > 0) chk("b2b_gap", w, FRAME);
    end
    valid = 1'b0;
    wait_done();
    chk("hello_done_count", n_done - d0, 13);

    // Handshake under busy
    repeat (3) @(negedge clk);
    send(8'h65, 1'b0, w);
    for (int t = 1; t < FRAME; t++) begin
      @(negedge clk);
      chk("ready_low_in_frame", ready, 0);
      if (t == 40) begin
        valid = 1'b1;
        data_in = 8'hFF;
      end
      if (t == 43) valid = 1'b0;
      if (t > 40 && t < 44) data_in = 8'($urandom);
    end
    @(negedge clk);
    chk("busy_frame_done", done, 1);
    repeat (2 * FRAME) @(negedge clk);
    chk("ignored_byte_not_sent", exp_q.size(), 0);

    // Reset mid-frame during data bit 3
    send(8'h6F, 1'b0, w);
    repeat (4 * N + N / 2) @(negedge clk);
    exp_q.delete();
    rstn = 1'b0;
    @(negedge clk);
    chk("midreset_tx", tx, 1);
    chk("midreset_ready", ready, 1);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    send(8'h21, 1'b0, w);
    wait_done();

    // Parity pair (checked by the receiver model when PARITY_EN is defined)
    send(8'h57, 1'b1, w);
    send(8'h48, 1'b0, w);
    chk("parity_pair_gap", w, FRAME);
    wait_done();

    // Randomised bytes with random gaps and random valid hold
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(8'($urandom), 1'($urandom_range(0, 1)), w);
    end
    valid = 1'b0;
    wait_done();

    begin
      int g;
      g = 0;
      while ((exp_q.size() != 0 || mon_active) && g < 4 * FRAME) begin
        @(negedge clk);
        g++;
      end
    end
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
